// File: rtl/control_config_contadores_pkg.sv
// Field codes and sequencer state encoding shared by the RTC field counters,
// the configuration sequencer and the VGA display control.
package control_config_contadores_pkg;

  localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
  localparam logic [3:0] CAMPO_SS      = 4'd1;
  localparam logic [3:0] CAMPO_MM      = 4'd2;
  localparam logic [3:0] CAMPO_HH      = 4'd3;
  localparam logic [3:0] CAMPO_DD      = 4'd4;
  localparam logic [3:0] CAMPO_MES     = 4'd5;
  localparam logic [3:0] CAMPO_AN      = 4'd6;
  localparam logic [3:0] CAMPO_TMR_SS  = 4'd7;
  localparam logic [3:0] CAMPO_TMR_MM  = 4'd8;
  localparam logic [3:0] CAMPO_TMR_HH  = 4'd9;

  typedef enum logic {
    IDLE   = 1'b0,
    CONFIG = 1'b1
  } estado_t;

endpackage

// File: rtl/control_config_contadores_pulso_repeticion.sv
// One step button: rising-edge pulse, then a repeat after HOLD_CYC cycles and
// every REP_CYC cycles while the level stays high and the channel is enabled.
module pulso_repeticion #(
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic nivel_i,
  input  logic habilita_i,
  input  logic limpia_i,
  output logic pulso_o
);

  localparam int TW = $clog2(HOLD_CYC + 1);
  localparam logic [TW-1:0] TC_HOLD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TC_REP  = TW'(REP_CYC - 1);

  logic          nivel_prev_q;
  logic          activo_q, activo_d;
  logic          fase_rep_q, fase_rep_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;
  logic          subida;
  logic [TW-1:0] tc;

  assign subida = nivel_i & ~nivel_prev_q;
  assign tc     = fase_rep_q ? TC_REP : TC_HOLD;

  // activo_q is only set by an accepted edge, so a level held through entry
  // into CONFIG or through a field change needs a release and re-press.
  always_comb begin
    activo_d   = activo_q;
    fase_rep_d = fase_rep_q;
    cnt_d      = cnt_q;
    pulso_d    = 1'b0;
    if (!nivel_i || !habilita_i || limpia_i) begin
      activo_d   = 1'b0;
      fase_rep_d = 1'b0;
      cnt_d      = '0;
    end else if (subida) begin
      activo_d   = 1'b1;
      fase_rep_d = 1'b0;
      cnt_d      = '0;
      pulso_d    = 1'b1;
    end else if (activo_q) begin
      if (cnt_q == tc) begin
        pulso_d    = 1'b1;
        fase_rep_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nivel_prev_q <= 1'b0;
      activo_q     <= 1'b0;
      fase_rep_q   <= 1'b0;
      cnt_q        <= '0;
      pulso_q      <= 1'b0;
    end else begin
      nivel_prev_q <= nivel_i;
      activo_q     <= activo_d;
      fase_rep_q   <= fase_rep_d;
      cnt_q        <= cnt_d;
      pulso_q      <= pulso_d;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/control_config_contadores.sv
// Configuration sequencer: mode FSM, field-select register and two
// auto-repeating step channels feeding the RTC field counters.
//   state  | meaning
//   IDLE   | normal timekeeping, no field selected, no step pulses
//   CONFIG | a field is selected; der/izq move it, arriba/abajo step it
module control_config_contadores
  import control_config_contadores_pkg::*;
#(
  parameter int N_FIELDS = 9,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic       modo_config,
  output logic [3:0] contadores,
  output logic       Arriba,
  output logic       Abajo
);

  localparam logic [3:0] CAMPO_MAX = 4'(N_FIELDS);

  estado_t    estado_q, estado_d;
  logic [3:0] campo_q, campo_d;
  logic       cfg_prev_q, der_prev_q, izq_prev_q;
  logic       sube_cfg, sube_der, sube_izq;
  logic       cambio_campo, habilita;
  logic       up_q, dn_q;

  assign sube_cfg = btn_config & ~cfg_prev_q;
  assign sube_der = btn_der & ~der_prev_q;
  assign sube_izq = btn_izq & ~izq_prev_q;

  always_comb begin
    estado_d     = estado_q;
    campo_d      = campo_q;
    cambio_campo = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (sube_cfg) begin
          estado_d = CONFIG;
          campo_d  = CAMPO_SS;
        end
      end
      CONFIG: begin
        if (sube_cfg) begin
          estado_d = IDLE;
          campo_d  = CAMPO_NINGUNO;
        end else if (sube_der && !sube_izq) begin
          campo_d      = (campo_q == CAMPO_MAX) ? CAMPO_SS : campo_q + 4'd1;
          cambio_campo = 1'b1;
        end else if (sube_izq && !sube_der) begin
          campo_d      = (campo_q == CAMPO_SS) ? CAMPO_MAX : campo_q - 4'd1;
          cambio_campo = 1'b1;
        end
      end
      default: begin
        estado_d = IDLE;
        campo_d  = CAMPO_NINGUNO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= IDLE;
      campo_q    <= CAMPO_NINGUNO;
      cfg_prev_q <= 1'b0;
      der_prev_q <= 1'b0;
      izq_prev_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      campo_q    <= campo_d;
      cfg_prev_q <= btn_config;
      der_prev_q <= btn_der;
      izq_prev_q <= btn_izq;
    end
  end

  // Leaving CONFIG must suppress a step pulse landing in the same cycle.
  assign habilita = (estado_q == CONFIG) && !sube_cfg;
  assign up_q     = btn_arriba & ~btn_abajo;
  assign dn_q     = btn_abajo & ~btn_arriba;

  pulso_repeticion #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_arriba (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .nivel_i    (up_q),
    .habilita_i (habilita),
    .limpia_i   (cambio_campo),
    .pulso_o    (Arriba)
  );

  pulso_repeticion #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_abajo (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .nivel_i    (dn_q),
    .habilita_i (habilita),
    .limpia_i   (cambio_campo),
    .pulso_o    (Abajo)
  );

  assign modo_config = (estado_q == CONFIG);
  assign contadores  = campo_q;

endmodule

// File: tb/tb_control_config_contadores.sv
// Directed bench for the configuration sequencer (N_FIELDS=9, HOLD_CYC=10, REP_CYC=4).
module tb_control_config_contadores;

  logic       clk;
  logic       reset;
  logic       btn_config, btn_der, btn_izq, btn_arriba, btn_abajo;
  logic       modo_config;
  logic [3:0] contadores;
  logic       Arriba, Abajo;

  int n_checks = 0;
  int n_fail   = 0;

  control_config_contadores #(.N_FIELDS(9), .HOLD_CYC(10), .REP_CYC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_config  (btn_config),
    .btn_der     (btn_der),
    .btn_izq     (btn_izq),
    .btn_arriba  (btn_arriba),
    .btn_abajo   (btn_abajo),
    .modo_config (modo_config),
    .contadores  (contadores),
    .Arriba      (Arriba),
    .Abajo       (Abajo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_der();
    btn_der = 1'b1; step(); btn_der = 1'b0; step();
  endtask

  task automatic press_izq();
    btn_izq = 1'b1; step(); btn_izq = 1'b0; step();
  endtask

  task automatic press_config();
    btn_config = 1'b1; step(); btn_config = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    n_checks++; if (modo_config !== 1'b0) begin n_fail++; $display("FAIL reset_modo got=%b exp=0", modo_config); end
    n_checks++; if (contadores !== 4'd0) begin n_fail++; $display("FAIL reset_contadores got=%0d exp=0", contadores); end
    n_checks++; if (Arriba !== 1'b0) begin n_fail++; $display("FAIL reset_arriba got=%b exp=0", Arriba); end
    n_checks++; if (Abajo !== 1'b0) begin n_fail++; $display("FAIL reset_abajo got=%b exp=0", Abajo); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_config_toggle();
    btn_config = 1'b1; step();
    n_checks++; if (modo_config !== 1'b1) begin n_fail++; $display("FAIL enter_modo got=%b exp=1", modo_config); end
    n_checks++; if (contadores !== 4'd1) begin n_fail++; $display("FAIL enter_contadores got=%0d exp=1", contadores); end
    btn_config = 1'b0; step();
    n_checks++; if (contadores !== 4'd1) begin n_fail++; $display("FAIL hold_contadores got=%0d exp=1", contadores); end
    btn_config = 1'b1; step();
    n_checks++; if (contadores !== 4'd0) begin n_fail++; $display("FAIL exit_contadores got=%0d exp=0", contadores); end
    n_checks++; if (modo_config !== 1'b0) begin n_fail++; $display("FAIL exit_modo got=%b exp=0", modo_config); end
    btn_config = 1'b0; step();
  endtask

  task automatic test_field_select();
    press_config();
    repeat (3) press_der();
    n_checks++; if (contadores !== 4'd4) begin n_fail++; $display("FAIL der_x3 got=%0d exp=4", contadores); end
    repeat (5) press_der();
    n_checks++; if (contadores !== 4'd9) begin n_fail++; $display("FAIL der_to_max got=%0d exp=9", contadores); end
    press_der();
    n_checks++; if (contadores !== 4'd1) begin n_fail++; $display("FAIL der_wrap got=%0d exp=1", contadores); end
    press_izq();
    n_checks++; if (contadores !== 4'd9) begin n_fail++; $display("FAIL izq_wrap got=%0d exp=9", contadores); end
    press_izq();
    n_checks++; if (contadores !== 4'd8) begin n_fail++; $display("FAIL izq_dec got=%0d exp=8", contadores); end
    btn_der = 1'b1; btn_izq = 1'b1; step();
    n_checks++; if (contadores !== 4'd8) begin n_fail++; $display("FAIL der_izq_same got=%0d exp=8", contadores); end
    btn_der = 1'b0; btn_izq = 1'b0; step();
    btn_config = 1'b1; btn_der = 1'b1; step();
    n_checks++; if (contadores !== 4'd0) begin n_fail++; $display("FAIL cfg_der_same got=%0d exp=0", contadores); end
    n_checks++; if (modo_config !== 1'b0) begin n_fail++; $display("FAIL cfg_der_modo got=%b exp=0", modo_config); end
    btn_config = 1'b0; btn_der = 1'b0; step();
    press_config();
    press_izq();
    n_checks++; if (contadores !== 4'd9) begin n_fail++; $display("FAIL reenter_izq got=%0d exp=9", contadores); end
  endtask

  task automatic test_repeat();
    logic exp;
    btn_arriba = 1'b1;
    for (int j = 1; j <= 35; j++) begin
      step();
      exp = (j == 1) || (j >= 11 && j <= 31 && ((j - 11) % 4) == 0);
      n_checks++; if (Arriba !== exp) begin n_fail++; $display("FAIL repeat_arriba k+%0d got=%b exp=%b", j, Arriba, exp); end
      n_checks++; if (Abajo !== 1'b0) begin n_fail++; $display("FAIL repeat_abajo k+%0d got=%b exp=0", j, Abajo); end
      if (j == 31) btn_arriba = 1'b0;
    end
  endtask

  task automatic test_both_high();
    btn_arriba = 1'b1;
    step();
    n_checks++; if (Arriba !== 1'b1) begin n_fail++; $display("FAIL both_first got=%b exp=1", Arriba); end
    step();
    n_checks++; if (Arriba !== 1'b0) begin n_fail++; $display("FAIL both_k2 got=%b exp=0", Arriba); end
    step();
    btn_abajo = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_checks++; if (Arriba !== 1'b0 || Abajo !== 1'b0) begin
        n_fail++; $display("FAIL both_quiet i=%0d got=%b%b exp=00", i, Arriba, Abajo);
      end
    end
    btn_abajo = 1'b0;
    step();
    n_checks++; if (Arriba !== 1'b1 || Abajo !== 1'b0) begin n_fail++; $display("FAIL both_return got=%b%b exp=10", Arriba, Abajo); end
    step();
    n_checks++; if (Arriba !== 1'b0) begin n_fail++; $display("FAIL both_after got=%b exp=0", Arriba); end
    btn_arriba = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_field_change_hold();
    btn_abajo = 1'b1;
    step();
    n_checks++; if (Abajo !== 1'b1) begin n_fail++; $display("FAIL fc_first got=%b exp=1", Abajo); end
    repeat (4) step();
    btn_der = 1'b1;
    step();
    n_checks++; if (contadores !== 4'd1) begin n_fail++; $display("FAIL fc_contadores got=%0d exp=1", contadores); end
    btn_der = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_checks++; if (Abajo !== 1'b0 || Arriba !== 1'b0) begin
        n_fail++; $display("FAIL fc_quiet i=%0d got=%b%b exp=00", i, Arriba, Abajo);
      end
    end
    btn_abajo = 1'b0;
    repeat (2) step();
    btn_abajo = 1'b1;
    step();
    n_checks++; if (Abajo !== 1'b1) begin n_fail++; $display("FAIL fc_repress got=%b exp=1", Abajo); end
    repeat (9) step();
    btn_config = 1'b1;
    step();
    n_checks++; if (Abajo !== 1'b0 || Arriba !== 1'b0) begin n_fail++; $display("FAIL exit_pulse got=%b%b exp=00", Arriba, Abajo); end
    n_checks++; if (contadores !== 4'd0) begin n_fail++; $display("FAIL exit_hold_contadores got=%0d exp=0", contadores); end
    btn_config = 1'b0; btn_abajo = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_hold();
    press_config();
    btn_arriba = 1'b1;
    step();
    n_checks++; if (Arriba !== 1'b1) begin n_fail++; $display("FAIL rst_first got=%b exp=1", Arriba); end
    repeat (7) step();
    reset = 1'b0;
    #1;
    n_checks++; if (contadores !== 4'd0) begin n_fail++; $display("FAIL rst_async_contadores got=%0d exp=0", contadores); end
    n_checks++; if (modo_config !== 1'b0) begin n_fail++; $display("FAIL rst_async_modo got=%b exp=0", modo_config); end
    n_checks++; if (Arriba !== 1'b0 || Abajo !== 1'b0) begin n_fail++; $display("FAIL rst_async_pulses got=%b%b exp=00", Arriba, Abajo); end
    repeat (2) step();
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_checks++; if (Arriba !== 1'b0 || modo_config !== 1'b0) begin
        n_fail++; $display("FAIL rst_release i=%0d got=%b%b exp=00", i, Arriba, modo_config);
      end
    end
    btn_config = 1'b1;
    step();
    n_checks++; if (contadores !== 4'd1) begin n_fail++; $display("FAIL held_entry_contadores got=%0d exp=1", contadores); end
    btn_config = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      n_checks++; if (Arriba !== 1'b0) begin n_fail++; $display("FAIL held_entry i=%0d got=%b exp=0", i, Arriba); end
    end
    btn_arriba = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    btn_config = 1'b0; btn_der = 1'b0; btn_izq = 1'b0;
    btn_arriba = 1'b0; btn_abajo = 1'b0;
    test_reset();
    test_config_toggle();
    test_field_select();
    test_repeat();
    test_both_high();
    test_field_change_hold();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
